hazard_sched: RTL and testbench

- Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Compares D-stage operand use times (Tuse) against E/M producer ready times (Tnew) and derives the enables for PC and IF/ID, plus the flush (bubble) for ID/EX.
- Owns a cycle counter that models multiply/divide busy time and holds HI/LO-dependent instructions in D.
- Also produces D-stage forwarding selects.

---
 rtl/hazard_sched_pkg.sv | 17 +
 rtl/hazard_sched_md_busy_cnt.sv | 32 +++
 rtl/hazard_sched.sv | 100 ++++++++++
 tb/tb_hazard_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sched_pkg.sv
// Shared constants and types for the pipeline hazard scheduler.
// Holds operand-use sentinels, forwarding select encodings and multiply/divide latencies.
package hazard_sched_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/hazard_sched_md_busy_cnt.sv
// Multiply/divide busy-time model: a down counter loaded when a mult/div leaves E.
// md_busy stays high for exactly the programmed latency after the start edge.
module md_busy_cnt
    import hazard_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic md_busy
);

    logic [CNT_W-1:0] cnt;

    // A start while still busy simply reloads: the most recent operation wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_sched.sv
// Stall/flush scheduler and D-stage forwarding select for the 5-stage MIPS pipeline.
// Optional macro HAZARD_STALL_STAT_EN adds a free-running 32-bit stall cycle counter.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_flush,
    output logic        md_busy,
    output logic [1:0]  D_fwd_rs,
    output logic [1:0]  D_fwd_rt,
    output logic [31:0] stall_cnt
);

    logic     e_match_rs, e_match_rt, m_match_rs, m_match_rt;
    logic     stall_rs, stall_rt, stall_md, stall;
    fwd_sel_e fwd_rs, fwd_rt;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk     (clk),
        .reset   (reset),
        .start   (E_md_start),
        .div     (E_md_div),
        .md_busy (md_busy)
    );

    // $zero is never a real producer, so it cannot match.
    assign e_match_rs = (D_rs != 5'd0) && (E_wa == D_rs);
    assign e_match_rt = (D_rt != 5'd0) && (E_wa == D_rt);
    assign m_match_rs = (D_rs != 5'd0) && (M_wa == D_rs);
    assign m_match_rt = (D_rt != 5'd0) && (M_wa == D_rt);

    assign stall_rs = (e_match_rs && (E_tnew > D_tuse_rs)) ||
                      (m_match_rs && (M_tnew > D_tuse_rs));
    assign stall_rt = (e_match_rt && (E_tnew > D_tuse_rt)) ||
                      (m_match_rt && (M_tnew > D_tuse_rt));
    assign stall_md = D_is_md && (md_busy || E_md_start);
    assign stall    = stall_rs | stall_rt | stall_md;

    assign pc_en    = ~stall;
    assign fd_en    = ~stall;
    assign de_flush = stall;

    // The younger producer (E) wins when both stages write the same register.
    always_comb begin
        fwd_rs = FWD_RF;
        fwd_rt = FWD_RF;
        if (e_match_rs && (E_tnew == 2'd0)) begin
            fwd_rs = FWD_E;
        end else if (m_match_rs && (M_tnew == 2'd0)) begin
            fwd_rs = FWD_M;
        end
        if (e_match_rt && (E_tnew == 2'd0)) begin
            fwd_rt = FWD_E;
        end else if (m_match_rt && (M_tnew == 2'd0)) begin
            fwd_rt = FWD_M;
        end
    end

    assign D_fwd_rs = fwd_rs;
    assign D_fwd_rt = fwd_rt;

`ifdef HAZARD_STALL_STAT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed scenarios plus random traffic
// compared against a behavioural model built on absolute cycle numbers.
module tb_hazard_sched;
    import hazard_sched_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_wa, M_wa;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_is_md, E_md_start, E_md_div;
    logic        pc_en, fd_en, de_flush, md_busy;
    logic [1:0]  D_fwd_rs, D_fwd_rt;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Model state: number of edges seen, the edge at which the md unit goes idle,
    // and the number of stalled non-reset cycles.
    int          edges     = 0;
    int          busy_end  = 0;
    logic [31:0] stat_model = '0;

    hazard_sched dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_is_md    (D_is_md),
        .E_wa       (E_wa),
        .E_tnew     (E_tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .M_wa       (M_wa),
        .M_tnew     (M_tnew),
        .pc_en      (pc_en),
        .fd_en      (fd_en),
        .de_flush   (de_flush),
        .md_busy    (md_busy),
        .D_fwd_rs   (D_fwd_rs),
        .D_fwd_rt   (D_fwd_rt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic exp_busy();
        return edges < busy_end;
    endfunction

    function automatic logic operand_stalls(input logic [4:0] r, input logic [1:0] tuse);
        if (r == 5'd0) return 1'b0;
        if (E_wa == r && int'(E_tnew) > int'(tuse)) return 1'b1;
        if (M_wa == r && int'(M_tnew) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_stall();
        return operand_stalls(D_rs, D_tuse_rs) || operand_stalls(D_rt, D_tuse_rt) ||
               (D_is_md && (exp_busy() || E_md_start));
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] r);
        if (r == 5'd0) return 2'd0;
        if (E_wa == r && E_tnew == 2'd0) return 2'd1;
        if (M_wa == r && M_tnew == 2'd0) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] exp_stat();
`ifdef HAZARD_STALL_STAT_EN
        return stat_model;
`else
        return 32'd0;
`endif
    endfunction

    task automatic clear_inputs();
        D_rs = 0; D_rt = 0; D_tuse_rs = TUSE_NONE; D_tuse_rt = TUSE_NONE;
        D_is_md = 0; E_wa = 0; E_tnew = 0; E_md_start = 0; E_md_div = 0;
        M_wa = 0; M_tnew = 0;
    endtask

    // Advance one clock and move the model along with the inputs sampled at that edge.
    task automatic tick();
        logic s;
        s = exp_stall();
        @(posedge clk);
        edges++;
        if (reset) begin
            busy_end   = edges;
            stat_model = '0;
        end else begin
            if (E_md_start) busy_end = edges + (E_md_div ? DIV_N : MULT_N);
            if (s) stat_model = stat_model + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total++; if (pc_en !== 1'b1)    begin bad++; $display("[TB] FAIL reset_pc_en got=%b exp=1", pc_en); end
        total++; if (fd_en !== 1'b1)    begin bad++; $display("[TB] FAIL reset_fd_en got=%b exp=1", fd_en); end
        total++; if (de_flush !== 1'b0) begin bad++; $display("[TB] FAIL reset_de_flush got=%b exp=0", de_flush); end
        total++; if (md_busy !== 1'b0)  begin bad++; $display("[TB] FAIL reset_md_busy got=%b exp=0", md_busy); end
        total++; if (D_fwd_rs !== 2'd0 || D_fwd_rt !== 2'd0) begin
            bad++; $display("[TB] FAIL reset_fwd got=%0d/%0d exp=0/0", D_fwd_rs, D_fwd_rt);
        end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_lw_use();
        clear_inputs();
        E_wa = 8; E_tnew = 2; D_rs = 8; D_tuse_rs = 1;
        #1;
        total++; if ({pc_en, fd_en, de_flush} !== 3'b001) begin
            bad++; $display("[TB] FAIL lw_use_stall got=%b exp=001", {pc_en, fd_en, de_flush});
        end
        tick();
        E_wa = 0; E_tnew = 0; M_wa = 8; M_tnew = 1;
        #1;
        total++; if ({pc_en, fd_en, de_flush} !== 3'b110) begin
            bad++; $display("[TB] FAIL lw_use_release got=%b exp=110", {pc_en, fd_en, de_flush});
        end
        tick();
        clear_inputs();
        E_wa = 8; E_tnew = 2; D_rs = 8; D_tuse_rs = TUSE_NONE;
        #1;
        total++; if (de_flush !== 1'b0) begin bad++; $display("[TB] FAIL no_hazard_unused got=%b exp=0", de_flush); end
        clear_inputs();
        E_wa = 9; E_tnew = 1; D_rt = 9; D_tuse_rt = 0;
        #1;
        total++; if (de_flush !== 1'b1) begin bad++; $display("[TB] FAIL rt_stall got=%b exp=1", de_flush); end
        tick();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        E_wa = 31; E_tnew = 0; D_rs = 31; D_tuse_rs = 0;
        #1;
        total++; if (D_fwd_rs !== 2'd1) begin bad++; $display("[TB] FAIL fwd_e got=%0d exp=1", D_fwd_rs); end
        M_wa = 31; M_tnew = 0;
        #1;
        total++; if (D_fwd_rs !== 2'd1) begin bad++; $display("[TB] FAIL fwd_e_prio got=%0d exp=1", D_fwd_rs); end
        E_wa = 0; D_rt = 31;
        #1;
        total++; if (D_fwd_rs !== 2'd2 || D_fwd_rt !== 2'd2) begin
            bad++; $display("[TB] FAIL fwd_m got=%0d/%0d exp=2/2", D_fwd_rs, D_fwd_rt);
        end
        clear_inputs();
        #1;
        total++; if (D_fwd_rs !== 2'd0 || de_flush !== 1'b0) begin
            bad++; $display("[TB] FAIL fwd_zero got=%0d/%b exp=0/0", D_fwd_rs, de_flush);
        end
        tick();
    endtask

    task automatic test_mult_timing();
        int stalls;
        clear_inputs();
        D_is_md = 1; E_md_start = 1; E_md_div = 0;
        stalls = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (de_flush === 1'b1) stalls++;
            total++; if (md_busy !== (c >= 1 && c <= MULT_N)) begin
                bad++; $display("[TB] FAIL mult_busy c=%0d got=%b exp=%b", c, md_busy, (c >= 1 && c <= MULT_N));
            end
            tick();
            E_md_start = 0;
        end
        total++; if (stalls !== MULT_N + 1) begin bad++; $display("[TB] FAIL mult_stalls got=%0d exp=%0d", stalls, MULT_N + 1); end
        clear_inputs();
    endtask

    task automatic test_div_reset();
        int busy_cycles;
        clear_inputs();
        E_md_start = 1; E_md_div = 1;
        tick();
        E_md_start = 0;
        busy_cycles = 0;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (md_busy === 1'b1) busy_cycles++;
            tick();
        end
        total++; if (busy_cycles !== DIV_N) begin bad++; $display("[TB] FAIL div_busy got=%0d exp=%0d", busy_cycles, DIV_N); end
        E_md_start = 1; E_md_div = 1; D_is_md = 1;
        tick();
        E_md_start = 0;
        tick();
        tick();
        reset = 1'b1;
        E_md_start = 1;
        tick();
        reset = 1'b0;
        E_md_start = 0;
        #1;
        total++; if (md_busy !== 1'b0 || de_flush !== 1'b0) begin
            bad++; $display("[TB] FAIL div_reset got=%b/%b exp=0/0", md_busy, de_flush);
        end
        clear_inputs();
    endtask

    task automatic test_stall_stat();
        logic [31:0] expect_cnt;
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        E_wa = 5; E_tnew = 2; D_rs = 5; D_tuse_rs = 0;
        for (int c = 0; c < 4; c++) tick();
        clear_inputs();
        #1;
`ifdef HAZARD_STALL_STAT_EN
        expect_cnt = 32'd4;
`else
        expect_cnt = 32'd0;
`endif
        total++; if (stall_cnt !== expect_cnt) begin bad++; $display("[TB] FAIL stat_count got=%0d exp=%0d", stall_cnt, expect_cnt); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL stat_reset got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_random();
        logic s;
        for (int c = 0; c < 400; c++) begin
            D_rs       = 5'($urandom_range(0, 3));
            D_rt       = 5'($urandom_range(0, 3));
            E_wa       = 5'($urandom_range(0, 3));
            M_wa       = 5'($urandom_range(0, 3));
            D_tuse_rs  = 2'($urandom_range(0, 3));
            D_tuse_rt  = 2'($urandom_range(0, 3));
            E_tnew     = 2'($urandom_range(0, 3));
            M_tnew     = 2'($urandom_range(0, 3));
            D_is_md    = ($urandom_range(0, 2) == 0);
            E_md_start = ($urandom_range(0, 9) == 0);
            E_md_div   = $urandom_range(0, 1) == 1;
            reset      = ($urandom_range(0, 49) == 0);
            #1;
            s = exp_stall();
            total++; if ({pc_en, fd_en, de_flush} !== {~s, ~s, s}) begin
                bad++; $display("[TB] FAIL rnd_stall c=%0d got=%b exp=%b", c, {pc_en, fd_en, de_flush}, {~s, ~s, s});
            end
            total++; if (md_busy !== exp_busy()) begin
                bad++; $display("[TB] FAIL rnd_busy c=%0d got=%b exp=%b", c, md_busy, exp_busy());
            end
            total++; if (D_fwd_rs !== exp_fwd(D_rs) || D_fwd_rt !== exp_fwd(D_rt)) begin
                bad++; $display("[TB] FAIL rnd_fwd c=%0d got=%0d/%0d exp=%0d/%0d", c, D_fwd_rs, D_fwd_rt, exp_fwd(D_rs), exp_fwd(D_rt));
            end
            total++; if (stall_cnt !== exp_stat()) begin
                bad++; $display("[TB] FAIL rnd_stat c=%0d got=%0d exp=%0d", c, stall_cnt, exp_stat());
            end
            tick();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_lw_use();
        test_forwarding();
        test_mult_timing();
        test_div_reset();
        test_stall_stat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
